// File: rtl/alu_secuencial.sv
// alu_secuencial: registered, parametrised ALU with a valid/ready request side
// and a valid/ready result side. Logic, shift, compare and add/subtract ops
// execute in one cycle on latched operands; signed multiply iterates a
// shift-add over N_BITS cycles on operand magnitudes and fixes the sign last.
// Result and flags are held in registers until the consumer takes them.

module alu_secuencial #(
  parameter int N_BITS  = 16,
  parameter int SH_BITS = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic [3:0]        op,
  output logic [N_BITS-1:0] resultado,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              zero,
  output logic              negativo,
  output logic              carry,
  output logic              overflow,
  output logic              err
);

  // Operation codes
  localparam logic [3:0] OP_SUB = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  // Iteration counter value at which the multiply has done all N_BITS steps
  // and only the sign correction remains.
  localparam logic [SH_BITS:0] MUL_LAST = N_BITS[SH_BITS:0];

  // EXEC is the one cycle in which a single-cycle op is evaluated on the
  // latched operands; it gives the one-edge gap between accept and result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched transaction
  logic [N_BITS-1:0]   a_q;
  logic [N_BITS-1:0]   b_q;
  logic [3:0]          op_q;

  // Multiplier datapath
  logic [2*N_BITS-1:0] mcand;
  logic [N_BITS-1:0]   mplier;
  logic [2*N_BITS-1:0] acc;
  logic [SH_BITS:0]    cnt;
  logic                neg;

  // Combinational results
  logic                accept;
  logic                mul_last;
  logic [N_BITS-1:0]   alu_res;
  logic                alu_c;
  logic                alu_v;
  logic                alu_err;
  logic [2*N_BITS-1:0] prod;
  logic [N_BITS-1:0]   mul_res;
  logic                mul_v;

  // Helpers for the add/sub/shift paths
  logic [N_BITS:0]     add_full;
  logic [N_BITS-1:0]   sub_res;
  logic [SH_BITS-1:0]  sh;
  logic                sh_big;

  // Magnitude of a two's-complement value; the most negative value maps to
  // its correct unsigned magnitude (e.g. 0x8000 -> 0x8000).
  function automatic logic [N_BITS-1:0] magnitude(input logic [N_BITS-1:0] v);
    logic [N_BITS-1:0] m;
    if (v[N_BITS-1]) begin
      m = ~v + {{(N_BITS-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  assign accept   = in_valid && (state == S_IDLE);
  assign mul_last = (state == S_MUL) && (cnt == MUL_LAST);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_nxt = S_MUL;
          end else begin
            state_nxt = S_EXEC;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        state_nxt = S_DONE;
      end
      S_MUL: begin
        if (cnt == MUL_LAST) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_MUL;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture operands and op code on acceptance; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= {N_BITS{1'b0}};
      b_q  <= {N_BITS{1'b0}};
      op_q <= 4'd0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
  end

  // Shift-add multiplier on magnitudes: one partial product per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= {(2*N_BITS){1'b0}};
      mplier <= {N_BITS{1'b0}};
      acc    <= {(2*N_BITS){1'b0}};
      cnt    <= {(SH_BITS+1){1'b0}};
      neg    <= 1'b0;
    end else if (accept) begin
      mcand  <= {{N_BITS{1'b0}}, magnitude(a)};
      mplier <= magnitude(b);
      acc    <= {(2*N_BITS){1'b0}};
      cnt    <= {(SH_BITS+1){1'b0}};
      neg    <= a[N_BITS-1] ^ b[N_BITS-1];
    end else if ((state == S_MUL) && (cnt != MUL_LAST)) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + {{SH_BITS{1'b0}}, 1'b1};
    end
  end

  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_res  = a_q - b_q;
  assign sh       = b_q[SH_BITS-1:0];
  // Any bit of b above the shift field means the amount is >= N_BITS.
  assign sh_big   = |b_q[N_BITS-1:SH_BITS];

  // Single-cycle operation results and add/sub carry/overflow
  always_comb begin
    alu_res = {N_BITS{1'b0}};
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_SUB: begin
        alu_res = sub_res;
        alu_c   = (a_q < b_q);
        alu_v   = (a_q[N_BITS-1] != b_q[N_BITS-1]) &&
                  (sub_res[N_BITS-1] != a_q[N_BITS-1]);
      end
      OP_ADD: begin
        alu_res = add_full[N_BITS-1:0];
        alu_c   = add_full[N_BITS];
        alu_v   = (a_q[N_BITS-1] == b_q[N_BITS-1]) &&
                  (add_full[N_BITS-1] != a_q[N_BITS-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_SLL: begin
        if (sh_big) begin
          alu_res = {N_BITS{1'b0}};
        end else begin
          alu_res = a_q << sh;
        end
      end
      OP_SRL: begin
        if (sh_big) begin
          alu_res = {N_BITS{1'b0}};
        end else begin
          alu_res = a_q >> sh;
        end
      end
      OP_SRA: begin
        if (sh_big) begin
          alu_res = {N_BITS{a_q[N_BITS-1]}};
        end else begin
          alu_res = $signed(a_q) >>> sh;
        end
      end
      OP_SLT: begin
        alu_res = {{(N_BITS-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      end
      OP_MUL: begin
        // Multiply never passes through EXEC; keep results neutral.
        alu_res = {N_BITS{1'b0}};
      end
      default: begin
        alu_res = {N_BITS{1'b0}};
        alu_err = 1'b1;
      end
    endcase
  end

  // Sign correction and range check of the full 2N-bit product
  always_comb begin
    prod = acc;
    if (neg) begin
      prod = ~acc + {{(2*N_BITS-1){1'b0}}, 1'b1};
    end else begin
      prod = acc;
    end
    mul_res = prod[N_BITS-1:0];
    // Representable iff the upper N+1 bits are all copies of the sign.
    mul_v   = !((&prod[2*N_BITS-1:N_BITS-1]) || (~|prod[2*N_BITS-1:N_BITS-1]));
  end

  // Result/flag registers: loaded when an op finishes, held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultado <= {N_BITS{1'b0}};
      zero      <= 1'b0;
      negativo  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else if (state == S_EXEC) begin
      resultado <= alu_res;
      zero      <= (alu_res == {N_BITS{1'b0}});
      negativo  <= alu_res[N_BITS-1];
      carry     <= alu_c;
      overflow  <= alu_v;
      err       <= alu_err;
    end else if (mul_last) begin
      resultado <= mul_res;
      zero      <= (mul_res == {N_BITS{1'b0}});
      negativo  <= mul_res[N_BITS-1];
      carry     <= 1'b0;
      overflow  <= mul_v;
      err       <= 1'b0;
    end
  end

endmodule
